// File: rtl/i2s_sample_feeder.sv
// Stereo sample FIFO feeding an I2S DAC serializer. Pairs are written with a
// valid/ready handshake and released once per LR frame, late in the LR-high
// half, as a single-cycle valid pulse. An empty FIFO at release time produces
// a zero pair and is recorded as an underrun.
module i2s_sample_feeder #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned BCLK_OFFSET = 28
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_codec_bit_clock,
  input  logic                   i_codec_lr_clock,
  input  logic                   i_enable,
  input  logic [WIDTH-1:0]       i_sample_left,
  input  logic [WIDTH-1:0]       i_sample_right,
  input  logic                   i_sample_valid,
  output logic                   o_sample_ready,
  output logic [WIDTH-1:0]       o_data_left,
  output logic [WIDTH-1:0]       o_data_right,
  output logic                   o_data_valid,
  output logic [$clog2(DEPTH):0] o_fifo_level,
  output logic                   o_underrun,
  output logic [15:0]            o_underrun_count,
  input  logic                   i_clear_status
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned LW         = AW + 1;
  localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);
  // Counter value that the next qualifying bit-clock edge turns into BCLK_OFFSET.
  localparam logic [4:0]  HIT_COUNT  = 5'(BCLK_OFFSET - 1);

  // Synchronizers and edge detection
  logic bclk_meta, bclk_sync, bclk_dly, bclk_rise;
  logic lr_meta, lr_sync, lr_dly, lr_rise;

  // Frame timing
  logic [4:0] frame_count;
  logic       hit;
  logic       fired;
  logic       en_frame;
  logic       fire_now;

  // FIFO storage and state
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        level, level_next;
  logic               full, push, pop, underrun_evt;

  // Two-flop synchronizers, delay flop and registered rising-edge flags
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bclk_meta <= 1'b0;
      bclk_sync <= 1'b0;
      bclk_dly  <= 1'b0;
      bclk_rise <= 1'b0;
      lr_meta   <= 1'b0;
      lr_sync   <= 1'b0;
      lr_dly    <= 1'b0;
      lr_rise   <= 1'b0;
    end else begin
      bclk_meta <= i_codec_bit_clock;
      bclk_sync <= bclk_meta;
      bclk_dly  <= bclk_sync;
      bclk_rise <= bclk_sync & ~bclk_dly;
      lr_meta   <= i_codec_lr_clock;
      lr_sync   <= lr_meta;
      lr_dly    <= lr_sync;
      lr_rise   <= lr_sync & ~lr_dly;
    end
  end

  // A frame boundary wins over a pending hit so a short frame never releases.
  assign fire_now = hit & ~fired & en_frame & ~lr_rise;

  // Bit counter within the LR-high half, one-shot release flag, per-frame enable
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_count <= 5'd0;
      hit         <= 1'b0;
      fired       <= 1'b0;
      en_frame    <= 1'b0;
    end else if (lr_rise) begin
      frame_count <= 5'd0;
      hit         <= 1'b0;
      fired       <= 1'b0;
      en_frame    <= i_enable;
    end else begin
      if (bclk_rise && lr_sync && frame_count != 5'd31) begin
        frame_count <= frame_count + 5'd1;
      end
      hit <= bclk_rise & lr_sync & (frame_count == HIT_COUNT);
      if (fire_now) begin
        fired <= 1'b1;
      end
    end
  end

  assign full           = (level == FULL_LEVEL);
  assign o_sample_ready = ~full;
  assign o_fifo_level   = level;
  assign push           = i_sample_valid & ~full;
  assign pop            = fire_now & (level != '0);
  assign underrun_evt   = fire_now & (level == '0);

  // Occupancy next state; simultaneous push and pop leaves it unchanged
  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Sample storage; contents are don't-care outside the occupied window
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= {i_sample_left, i_sample_right};
    end
  end

  // FIFO pointers and level; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
    end
  end

  // Release outputs: popped pair or zeros, held until the next release
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data_left  <= '0;
      o_data_right <= '0;
      o_data_valid <= 1'b0;
    end else begin
      o_data_valid <= fire_now;
      if (fire_now) begin
        if (pop) begin
          {o_data_left, o_data_right} <= mem[rd_ptr];
        end else begin
          o_data_left  <= '0;
          o_data_right <= '0;
        end
      end
    end
  end

  // Sticky underrun flag and saturating count; a coincident underrun beats clear
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_underrun       <= 1'b0;
      o_underrun_count <= 16'd0;
    end else if (underrun_evt) begin
      o_underrun <= 1'b1;
      if (i_clear_status) begin
        o_underrun_count <= 16'd1;
      end else if (o_underrun_count != 16'hFFFF) begin
        o_underrun_count <= o_underrun_count + 16'd1;
      end
    end else if (i_clear_status) begin
      o_underrun       <= 1'b0;
      o_underrun_count <= 16'd0;
    end
  end

endmodule

// File: doc/i2s_sample_feeder.md
Name: i2s_sample_feeder

Overview:
- Stereo sample FIFO directly upstream of the I2S DAC serializer.
- Accepts 24-bit left/right sample pairs from the DSP path with a valid/ready handshake.
- Releases exactly one pair per LR frame as a single-cycle valid pulse, timed late in the right half-frame, when the serializer is guaranteed idle.
- Zero-fills and flags underruns.

Parameters:
- DEPTH, 16, FIFO depth in sample pairs; power of 2, minimum 2.
- WIDTH, 24, sample width per channel.
- BCLK_OFFSET, 28, bit-clock rising edges after LR rising at which a pair is released; legal range 26..31 for 32-bit half-frames.

Ports:
- i_clock  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_codec_bit_clock  in  1  codec I2S bit clock, asynchronous.
- i_codec_lr_clock  in  1  codec I2S LR clock, asynchronous.
- i_enable  in  1  release enable.
- i_sample_left  in  WIDTH  write-side left sample.
- i_sample_right  in  WIDTH  write-side right sample.
- i_sample_valid  in  1  write request.
- o_sample_ready  out  1  FIFO not full.
- o_data_left  out  WIDTH  released left sample, to serializer i_data_left.
- o_data_right  out  WIDTH  released right sample, to serializer i_data_right.
- o_data_valid  out  1  one-cycle release pulse, to serializer i_data_valid.
- o_fifo_level  out  log2(DEPTH)+1  current occupancy.
- o_underrun  out  1  sticky underrun flag.
- o_underrun_count  out  16  saturating underrun count.
- i_clear_status  in  1  clears o_underrun and o_underrun_count.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, o_fifo_level 0, o_sample_ready 1.
  - o_data_left/right 0, o_data_valid 0, o_underrun 0, o_underrun_count 0.
  - Synchronizer/delay registers 0. If LR is high at release, a rising edge is detected and treated as a frame start.
  - Reset mid-operation flushes all FIFO contents and aborts any pending release.
- Clock-domain crossing:
  - Bit and LR clocks each pass through 2 flops, then a delay flop.
  - Registered one-cycle rising-edge flags, matching the serializer's edge detection.
- Write side:
  - Push when i_sample_valid and o_sample_ready.
  - o_sample_ready = !full, from registered state.
  - i_sample_valid while full is ignored; no data corruption.
- Frame counter (5-bit):
  - Cleared to 0 on the LR rising flag.
  - Increments on each bit-clock rising flag while LR (synced) is high; saturates at 31.
  - A fire flag is cleared on LR rising.
- Release:
  - Triggered on the cycle after a bit-clock rising flag takes the counter to BCLK_OFFSET, provided the fire flag is clear and i_enable=1.
  - Sets the fire flag, which allows at most one release per frame.
  - Pulses o_data_valid for exactly one i_clock cycle.
- FIFO non-empty at release:
  - Pop head. o_data_left/right take the popped pair in the same cycle as o_data_valid.
  - Outputs hold until the next release.
- FIFO empty at release:
  - o_data_left/right = 0, o_data_valid still pulses.
  - o_underrun set; o_underrun_count increments, saturating at 0xFFFF.
- i_enable=0: no release, no underrun accounting, FIFO keeps filling. Enable changes take effect at the next frame.
- Short frame: if LR rises before the counter reaches BCLK_OFFSET, no release occurs for that frame.
- Simultaneous push and pop:
  - Level unchanged.
  - At full, push is blocked by registered ready; the slot frees next cycle.
  - At empty, no bypass; the release is an underrun and the pushed pair is stored.
- Pointers wrap modulo DEPTH. Level ranges 0..DEPTH.
- i_clear_status: clears both status outputs. If asserted in the same cycle as an underrun, the underrun wins: flag=1, count=1.

Test Plan:
- Reset, then push pairs L=0x000001/R=0xFFFFFF and L=0x7FFFFF/R=0x800000; run 64-bclk frames -> o_fifo_level 2 then 0. One valid pulse per frame, 28 bclk rising edges after each LR rising, carrying the pairs in order.
- Push 17 pairs with DEPTH=16 and i_enable=0 -> 16 accepted, o_sample_ready=0 at level 16. The 17th is dropped; its data never appears on the read side.
- Empty FIFO, i_enable=1, 3 frames -> 3 valid pulses with zero data, o_underrun=1, o_underrun_count=3. Pulse i_clear_status -> both 0.
- Push and release in the same cycle at level 1, then at level 0 -> level 1→1; at level 0 an underrun is counted and level ends at 1.
- Assert i_reset_n=0 mid-frame with level 5 -> outputs 0 immediately, level 0. After release, the first frame with an empty FIFO underruns.
- Frame with LR toggling every 20 bclks (short half-frame) -> no o_data_valid, FIFO level unchanged.
